// File: rtl/ps2_tx_pkg.sv
// Shared types and helpers for the PS/2 device-side transmitter.
//   state_e     : transmitter FSM states
//   FRAME_BITS  : bits per PS/2 frame (start, 8 data, parity, stop)
//   CNT_W       : width of the half-phase / gap counter
//   BIT_IDX_W   : width of the frame bit index
//   odd_parity  : parity bit that makes the 9-bit {parity,data} word odd
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    GAP,
    INHIBIT
  } state_e;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned CNT_W      = 10;
  localparam int unsigned BIT_IDX_W  = 4;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small synchronous byte FIFO feeding the PS/2 transmitter.
//   clock, reset : system clock, async active-high reset
//   push, push_data : write strobe and byte; ignored when full unless popping
//   pop          : remove head byte (ignored when empty)
//   head         : byte at the read pointer
//   count        : bytes held; full / empty flags are registered
module ps2_tx_fifo
  import ps2_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic [FIFO_DEPTH_LOG2:0]   count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_FW = FIFO_DEPTH_LOG2 + 1;

  logic [7:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_ok, pop_ok;

  // A write into a full FIFO is still taken when the head leaves on the same edge.
  assign push_ok = push & (~full_q | pop);
  assign pop_ok  = pop & ~empty_q;

  // Pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FW'(DEPTH));
    empty_d = (count_d == CNT_FW'(0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side (keyboard end) PS/2 transmitter with a byte FIFO.
//   clock, reset   : system clock, async active-high reset
//   tx_data/valid  : scan-code write port; tx_ready = FIFO not full
//   fifo_count     : bytes held, including the one on the wire
//   busy           : FSM not idle
//   frame_done     : pulse when the stop bit's low phase ends
//   frame_abort    : pulse when the host inhibits a frame mid-bit
//   ps2_clock_in   : sensed wired-AND clock line (low = host inhibit)
//   ps2_clock/data : device line drives, 1 = released
module ps2_device_tx
  import ps2_tx_pkg::*;
#(
  parameter int unsigned HALF_PERIOD     = 3,
  parameter int unsigned GAP_CYCLES      = 6,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       frame_abort,
  input  logic                       ps2_clock_in,
  output logic                       ps2_clock,
  output logic                       ps2_data
);

  localparam logic [CNT_W-1:0]     HP_LOAD  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0]     GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [BIT_IDX_W-1:0]    next_idx;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic                    hi_seen_q, hi_seen_d;
  logic                    ps2_clock_q, ps2_clock_d;
  logic                    ps2_data_q, ps2_data_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;
  logic                    frame_abort_q, frame_abort_d;

  logic                    fifo_pop_c;
  logic [7:0]              fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;

  ps2_tx_fifo #(
    .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (fifo_pop_c),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign next_idx = bit_idx_q + BIT_IDX_W'(1);

  // Next-state, phase timing and line drive.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    frame_d       = frame_q;
    hi_seen_d     = hi_seen_q;
    ps2_clock_d   = ps2_clock_q;
    ps2_data_d    = ps2_data_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    fifo_pop_c    = 1'b0;

    case (state_q)
      IDLE: begin
        ps2_clock_d = 1'b1;
        ps2_data_d  = 1'b1;
        // Head stays in the FIFO until the frame completes so an abort can resend it.
        if (!fifo_empty && ps2_clock_in) begin
          state_d     = SETUP;
          bit_idx_d   = '0;
          frame_d     = {1'b1, odd_parity(fifo_head), fifo_head, 1'b0};
          ps2_data_d  = 1'b0;
          cnt_d       = HP_LOAD;
        end
      end

      SETUP: begin
        // Clock is released here, so a low sense can only be the host pulling it.
        if (!ps2_clock_in) begin
          state_d       = INHIBIT;
          ps2_clock_d   = 1'b1;
          ps2_data_d    = 1'b1;
          frame_abort_d = 1'b1;
          hi_seen_d     = 1'b0;
        end else if (cnt_q == '0) begin
          state_d     = LOW;
          ps2_clock_d = 1'b0;
          cnt_d       = HP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      LOW: begin
        if (cnt_q == '0) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d      = GAP;
            fifo_pop_c   = 1'b1;
            frame_done_d = 1'b1;
            ps2_clock_d  = 1'b1;
            ps2_data_d   = 1'b1;
            cnt_d        = GAP_LOAD;
          end else begin
            state_d     = SETUP;
            bit_idx_d   = next_idx;
            ps2_clock_d = 1'b1;
            ps2_data_d  = frame_q[next_idx];
            cnt_d       = HP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      GAP: begin
        ps2_clock_d = 1'b1;
        ps2_data_d  = 1'b1;
        if (!ps2_clock_in) begin
          state_d   = INHIBIT;
          hi_seen_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      INHIBIT: begin
        ps2_clock_d = 1'b1;
        ps2_data_d  = 1'b1;
        // Require two consecutive high samples before trusting the release.
        if (ps2_clock_in) begin
          if (hi_seen_q) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            hi_seen_d = 1'b1;
          end
        end else begin
          hi_seen_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        ps2_clock_d = 1'b1;
        ps2_data_d  = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      frame_q       <= '1;
      hi_seen_q     <= 1'b0;
      ps2_clock_q   <= 1'b1;
      ps2_data_q    <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      frame_q       <= frame_d;
      hi_seen_q     <= hi_seen_d;
      ps2_clock_q   <= ps2_clock_d;
      ps2_data_q    <= ps2_data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign tx_ready    = ~fifo_full;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign ps2_clock   = ps2_clock_q;
  assign ps2_data    = ps2_data_q;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Scoreboard bench for ps2_device_tx: accepted bytes are queued as expected
// frames; a receiver-style monitor samples data on each clock fall and checks
// every completed frame against the queue.
module tb_ps2_device_tx;

  localparam int HP  = 3;
  localparam int GAP = 6;
  localparam int LG2 = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [LG2:0] fifo_count;
  logic       busy, frame_done, frame_abort;
  logic       ps2_clock_in, ps2_clock, ps2_data;
  logic       host_inhibit = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  // Wired-AND clock line: host pulls low to inhibit.
  assign ps2_clock_in = ps2_clock & ~host_inhibit;

  ps2_device_tx #(
    .HALF_PERIOD     (HP),
    .GAP_CYCLES      (GAP),
    .FIFO_DEPTH_LOG2 (LG2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .fifo_count   (fifo_count),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .ps2_clock_in (ps2_clock_in),
    .ps2_clock    (ps2_clock),
    .ps2_data     (ps2_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: host-side receiver, samples ps2_data at each ps2_clock fall.
  logic [10:0] rx_bits;
  int          rx_n = 0;
  logic        prev_clk = 1'b1;
  always @(negedge clock) begin
    logic [7:0]  b;
    logic [10:0] want;
    if (reset) begin
      rx_n = 0;
      prev_clk = 1'b1;
    end else begin
      if (frame_abort) rx_n = 0;
      if (prev_clk && !ps2_clock) begin
        rx_bits[rx_n] = ps2_data;
        rx_n++;
        if (rx_n == 11) begin
          rx_n = 0;
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", int'(rx_bits), -1);
          end else begin
            b = exp_q.pop_front();
            want = {1'b1, ($countones(b) % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
            chk($sformatf("frame_%02h", b), int'(rx_bits), int'(want));
          end
        end
      end
      prev_clk = ps2_clock;
    end
  end

  function automatic bit cond(input int which);
    case (which)
      0: return ps2_clock == 1'b0;
      1: return frame_done == 1'b1;
      2: return ps2_data == 1'b0 && ps2_clock == 1'b1;
      3: return ps2_clock == 1'b1;
      4: return !busy && exp_q.size() == 0;
      default: return 1'b1;
    endcase
  endfunction

  // Advance negedge by negedge until the condition holds or the budget expires.
  task automatic wait_cond(input int which, input int budget, input string name, output int c);
    int n = 0;
    while (!cond(which) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!cond(which)) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=not_seen required=within_%0d_cycles", name, budget);
    end
    c = cyc;
  endtask

  task automatic wait_falls(input int n);
    int c;
    for (int i = 0; i < n; i++) begin
      wait_cond(0, 200, "fall", c);
      wait_cond(3, 200, "rise", c);
    end
  endtask

  // Called at a negedge; edge of acceptance is the next posedge (cyc+1).
  task automatic push_byte(input logic [7:0] b, output bit acc, output int e0);
    tx_data  = b;
    tx_valid = 1'b1;
    acc = tx_ready;
    if (acc) exp_q.push_back(b);
    e0 = cyc + 1;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int e0, c, t, s, s_prev, r;
    int viol;
    logic [7:0] fifo_bytes[5];

    fifo_bytes[0] = 8'h1C; fifo_bytes[1] = 8'h32; fifo_bytes[2] = 8'h21;
    fifo_bytes[3] = 8'h23; fifo_bytes[4] = 8'h24;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    chk("rst_ps2_clock", ps2_clock, 1);
    chk("rst_ps2_data", ps2_data, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_abort", {frame_done, frame_abort}, 0);

    // Single byte with latency checks
    push_byte(8'h55, acc, e0);
    chk("single_acc", acc, 1);
    @(negedge clock);
    chk("start_bit_data", ps2_data, 0);
    chk("start_busy", busy, 1);
    wait_cond(0, 50, "first_fall", c);
    chk("first_fall_cycle", c - e0, 1 + HP);
    wait_cond(1, 200, "single_done", c);
    chk("frame_done_cycle", c - e0, 1 + 22 * HP);
    @(negedge clock);
    chk("done_pulse_width", frame_done, 0);
    chk("count_after_done", fifo_count, 0);

    // Parity corner bytes
    push_byte(8'h00, acc, e0);
    wait_cond(1, 200, "par0_done", c);
    @(negedge clock);
    push_byte(8'h01, acc, e0);
    wait_cond(1, 200, "par1_done", c);
    @(negedge clock);
    wait_cond(4, 200, "par_drain", c);

    // FIFO fill: fifth write refused, four frames back-to-back
    for (int i = 0; i < 5; i++) begin
      push_byte(fifo_bytes[i], acc, e0);
      if (i == 4) chk("fifth_refused", acc, 0);
      else chk($sformatf("fill_acc%0d", i), acc, 1);
    end
    chk("full_count", fifo_count, 4);
    chk("full_ready", tx_ready, 0);
    s_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_cond(1, 300, "fifo_done", t);
      @(negedge clock);
      if (k < 3) begin
        wait_cond(2, 100, "fifo_start", s);
        chk($sformatf("gap_high_cycles%0d", k), s - t, GAP + 1);
        if (k > 0) chk($sformatf("frame_period%0d", k), s - s_prev, 22 * HP + GAP + 1);
        s_prev = s;
      end
    end
    wait_cond(4, 300, "fifo_drain", c);
    repeat (20) @(negedge clock);
    chk("fifth_not_sent_busy", busy, 0);

    // Inhibit during bit 3 SETUP
    push_byte(8'h3A, acc, e0);
    wait_falls(3);
    host_inhibit = 1'b1;
    @(negedge clock);
    chk("abort_pulse", frame_abort, 1);
    chk("abort_lines", {ps2_clock, ps2_data}, 3);
    chk("abort_count", fifo_count, 1);
    viol = 0;
    repeat (9) begin
      @(negedge clock);
      if (fifo_count != 1 || ps2_data != 1'b1 || frame_abort != 1'b0) viol++;
    end
    chk("inhibit_hold", viol, 0);
    host_inhibit = 1'b0;
    r = cyc;
    wait_cond(2, 100, "resend_start", s);
    chk("resend_start_cycle", s - r, GAP + 3);
    viol = 0;
    while (!frame_done && cyc < s + 200) begin
      if (fifo_count != 1) viol++;
      @(negedge clock);
    end
    chk("resend_done", frame_done, 1);
    chk("count_held_during_resend", viol, 0);
    @(negedge clock);
    chk("count_after_resend", fifo_count, 0);
    wait_cond(4, 100, "inhibit_drain", c);

    // Idle inhibit: queued byte held back
    host_inhibit = 1'b1;
    push_byte(8'h5A, acc, e0);
    viol = 0;
    repeat (20) begin
      @(negedge clock);
      if (ps2_data != 1'b1 || busy != 1'b0) viol++;
    end
    chk("idle_inhibit_no_start", viol, 0);
    chk("idle_inhibit_count", fifo_count, 1);
    host_inhibit = 1'b0;
    wait_cond(2, 10, "idle_release_start", c);
    wait_cond(4, 200, "idle_release_drain", c);

    // Random traffic
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge clock);
      if (tx_ready) push_byte(8'($urandom), acc, e0);
    end
    wait_cond(4, 5000, "random_drain", c);

    // Reset mid-frame at bit 4
    push_byte(8'h77, acc, e0);
    wait_falls(4);
    #2 reset = 1'b1;
    #1;
    chk("midrst_lines", {ps2_clock, ps2_data}, 3);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_busy", busy, 0);
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    viol = 0;
    repeat (100) begin
      @(negedge clock);
      if (busy || !ps2_data || !ps2_clock) viol++;
    end
    chk("after_midrst_quiet", viol, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
